// File: rtl/gpr_mp_if.sv
// Register-file access bundle: two write ports, NUM_RD read ports and the scoreboard busy-set.
// The read-side outputs are combinational (zero-latency reads).
interface gpr_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
);
  logic                     we0;
  logic [ADDR_W-1:0]        waddr0;
  logic [DATA_W-1:0]        wdata0;
  logic                     we1;
  logic [ADDR_W-1:0]        waddr1;
  logic [DATA_W-1:0]        wdata1;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     busy_set;
  logic [ADDR_W-1:0]        busy_addr;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, busy_set, busy_addr,
    input  rdata, rd_busy
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, busy_set, busy_addr,
    output rdata, rd_busy
  );
endinterface

// File: rtl/gpr_mp.sv
// Multi-port register file with two write ports (port 1 has priority), optional
// write-to-read bypass and a per-register pending-write scoreboard.
module gpr_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input logic     clk,
  input logic     rst,
  gpr_mp_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              wr0_ok;
  logic              wr1_ok;
  logic              bset_ok;

  // Accesses to a hard-wired zero register are dropped before they reach any state.
  assign wr0_ok  = bus.we0 && !((ZERO_REG != 0) && (bus.waddr0 == '0));
  assign wr1_ok  = bus.we1 && !((ZERO_REG != 0) && (bus.waddr1 == '0));
  assign bset_ok = bus.busy_set && !((ZERO_REG != 0) && (bus.busy_addr == '0));

  // Port 1 is applied last so it wins a same-index collision; a new producer outranks a write.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr0_ok) begin
      regs_d[bus.waddr0] = bus.wdata0;
      busy_d[bus.waddr0] = 1'b0;
    end
    if (wr1_ok) begin
      regs_d[bus.waddr1] = bus.wdata1;
      busy_d[bus.waddr1] = 1'b0;
    end
    if (bset_ok) begin
      busy_d[bus.busy_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_c;
    logic              bz_c;

    assign ra = bus.raddr[k*ADDR_W +: ADDR_W];

    // A forwarded write supplies the data and also resolves the pending hazard.
    always_comb begin
      rd_c = regs_q[ra];
      bz_c = busy_q[ra];
      if (BYPASS != 0) begin
        if (wr0_ok && (bus.waddr0 == ra)) begin
          rd_c = bus.wdata0;
          bz_c = 1'b0;
        end
        if (wr1_ok && (bus.waddr1 == ra)) begin
          rd_c = bus.wdata1;
          bz_c = 1'b0;
        end
      end
      if (rst) begin
        rd_c = '0;
        bz_c = 1'b0;
      end
    end

    assign bus.rdata[k*DATA_W +: DATA_W] = rd_c;
    assign bus.rd_busy[k]                = bz_c;
  end
endmodule

// File: tb/tb_gpr_mp.sv
// Self-checking bench for gpr_mp (default parameters: 32x32, two read ports, zero reg, bypass).
`timescale 1ns/1ps
module tb_gpr_mp;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  gpr_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();

  gpr_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        bs;
    logic [4:0]  ba;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        eb0;
    logic        eb1;
  } vec_t;

  vec_t        tbl [13];
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: register file contents and busy flags as plain arrays.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (rst || a == 5'd0) return 32'h0;
    if (bus.we1 && bus.waddr1 == a) return bus.wdata1;
    if (bus.we0 && bus.waddr0 == a) return bus.wdata0;
    return m_regs[a];
  endfunction

  function automatic logic exp_bz(input logic [4:0] a);
    if (rst || a == 5'd0) return 1'b0;
    if ((bus.we1 && bus.waddr1 == a) || (bus.we0 && bus.waddr0 == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_commit();
    if (rst) return;
    if (bus.we0 && bus.waddr0 != 5'd0) begin
      m_regs[bus.waddr0] = bus.wdata0;
      m_busy[bus.waddr0] = 1'b0;
    end
    if (bus.we1 && bus.waddr1 != 5'd0) begin
      m_regs[bus.waddr1] = bus.wdata1;
      m_busy[bus.waddr1] = 1'b0;
    end
    if (bus.busy_set && bus.busy_addr != 5'd0) m_busy[bus.busy_addr] = 1'b1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_busy = 32'h0;
  endtask

  task automatic idle();
    bus.we0 = 1'b0; bus.waddr0 = '0; bus.wdata0 = '0;
    bus.we1 = 1'b0; bus.waddr1 = '0; bus.wdata1 = '0;
    bus.busy_set = 1'b0; bus.busy_addr = '0;
  endtask

  task automatic drive(input vec_t v);
    bus.we0 = v.we0; bus.waddr0 = v.wa0; bus.wdata0 = v.wd0;
    bus.we1 = v.we1; bus.waddr1 = v.wa1; bus.wdata1 = v.wd1;
    bus.busy_set = v.bs; bus.busy_addr = v.ba;
    bus.raddr = {v.ra1, v.ra0};
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [4:0] a0;
    logic [4:0] a1;
    a0 = bus.raddr[4:0];
    a1 = bus.raddr[9:5];
    chk({tag, "_rd0"}, bus.rdata[31:0], exp_rd(a0));
    chk({tag, "_rd1"}, bus.rdata[63:32], exp_rd(a1));
    chk({tag, "_bz0"}, 32'(bus.rd_busy[0]), 32'(exp_bz(a0)));
    chk({tag, "_bz1"}, 32'(bus.rd_busy[1]), 32'(exp_bz(a1)));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rdata"}, bus.rdata[31:0] | bus.rdata[63:32], 32'h0);
    chk({tag, "_busy"}, 32'(bus.rd_busy), 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_clear();
    idle();
    bus.raddr = '0;
    rst = 1'b1;

    // Directed table, applied starting from the reset state.
    //          we0  wa0    wd0            we1  wa1    wd1            bs   ba     ra0    ra1    e0             e1             eb0  eb1
    tbl[0]  = '{1'b1, 5'd5, 32'hAAAA_0000, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 5'd5, 5'd0, 32'h1234_5678, 32'h0,         1'b0, 1'b0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd5, 5'd5, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd7, 5'd5, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0,         32'h0,         1'b0, 1'b0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 5'd0, 32'h0,         32'h0,         1'b0, 1'b0};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b1, 5'd9, 5'd9, 5'd7, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd9, 5'd9, 32'h0,         32'h0,         1'b1, 1'b1};
    tbl[7]  = '{1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd9, 5'd7, 32'h0000_0099, 32'hDEAD_BEEF, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd9, 5'd9, 32'h0000_0099, 32'h0000_0099, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd3, 32'h3333_3333, 1'b1, 5'd3, 5'd3, 5'd9, 32'h3333_3333, 32'h0000_0099, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd3, 5'd3, 32'h3333_3333, 32'h3333_3333, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 5'd3, 32'h0000_0044, 1'b1, 5'd4, 32'h0000_0055, 1'b0, 5'd0, 5'd3, 5'd4, 32'h0000_0044, 32'h0000_0055, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd3, 5'd4, 32'h0000_0044, 32'h0000_0055, 1'b0, 1'b0};

    #3;
    check_zero("reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_rd0", i), bus.rdata[31:0], tbl[i].e0);
      chk($sformatf("vec%0d_rd1", i), bus.rdata[63:32], tbl[i].e1);
      chk($sformatf("vec%0d_bz0", i), 32'(bus.rd_busy[0]), 32'(tbl[i].eb0));
      chk($sformatf("vec%0d_bz1", i), 32'(bus.rd_busy[1]), 32'(tbl[i].eb1));
      tick();
    end

    // Random traffic against the model; a narrow address window forces collisions.
    for (int n = 0; n < 400; n++) begin
      int unsigned amax;
      amax = ($urandom_range(0, 2) == 0) ? 3 : 31;
      bus.we0       = 1'($urandom_range(0, 1));
      bus.waddr0    = 5'($urandom_range(0, amax));
      bus.wdata0    = $urandom;
      bus.we1       = 1'($urandom_range(0, 1));
      bus.waddr1    = 5'($urandom_range(0, amax));
      bus.wdata1    = $urandom;
      bus.busy_set  = 1'($urandom_range(0, 1));
      bus.busy_addr = 5'($urandom_range(0, amax));
      bus.raddr     = {5'($urandom_range(0, amax)), 5'($urandom_range(0, amax))};
      @(negedge clk);
      check_model("rand");
      tick();
    end

    // Fill r1..r31 and mark busy flags, then pulse reset mid-cycle.
    for (int a = 1; a < 32; a++) begin
      idle();
      bus.we0       = 1'b1;
      bus.waddr0    = 5'(a);
      bus.wdata0    = $urandom | 32'h1;
      bus.busy_set  = 1'b1;
      bus.busy_addr = 5'(a ^ 1);
      tick();
    end
    idle();
    bus.we1    = 1'b1;
    bus.waddr1 = 5'd5;
    bus.wdata1 = 32'hCAFE_F00D;
    bus.busy_set  = 1'b1;
    bus.busy_addr = 5'd7;
    bus.raddr  = {5'd8, 5'd5};
    @(negedge clk);
    check_model("pre_reset");
    #1 rst = 1'b1;
    #1 check_zero("during_reset");
    model_clear();
    @(posedge clk);
    #1 check_zero("reset_edge");
    #2 rst = 1'b0;
    idle();
    for (int a = 0; a < 32; a++) begin
      bus.raddr = {5'(31 - a), 5'(a)};
      #1 check_zero($sformatf("post_reset_r%0d", a));
    end

    // Normal operation resumes after reset.
    bus.we0 = 1'b1; bus.waddr0 = 5'd12; bus.wdata0 = 32'h0BAD_F00D;
    bus.busy_set = 1'b1; bus.busy_addr = 5'd13;
    tick();
    idle();
    bus.raddr = {5'd13, 5'd12};
    @(negedge clk);
    check_model("after_reset");
    chk("after_reset_r12", bus.rdata[31:0], 32'h0BAD_F00D);
    chk("after_reset_busy13", 32'(bus.rd_busy[1]), 32'h1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
